mod_updown_counter: RTL



---
 rtl/mod_updown_counter.sv | 80 ++++++++
 1 files changed

// File: rtl/mod_updown_counter.sv
// Modulo-MOD up/down counter with a DIV prescaler, synchronous clear/load and a cascade terminal count.
// Build option: define CNT_SAT_EN for saturating mode, where the count parks at 0 or MOD-1 instead of wrapping.
module mod_updown_counter #(
    parameter int W   = 4,
    parameter int MOD = 10,
    parameter int DIV = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_en,
    input  logic         i_up,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_ld_val,
    output logic [W-1:0] o_out,
    output logic         o_tc
);
    // Count is kept one bit wider than the output so MOD == 2**W compares and wraps cleanly.
    localparam logic [W:0] LP_MAX = (W+1)'(MOD - 1);
    localparam logic [W:0] LP_MOD = (W+1)'(MOD);

    logic [W:0] r_cnt;
    logic       w_tick;
    logic       w_at_max;
    logic       w_at_zero;
    logic       w_at_lim;
    logic [W:0] w_ld;
    logic [W:0] w_up_nx;
    logic [W:0] w_dn_nx;

    generate
        if (DIV == 1) begin : g_nops
            assign w_tick = i_en;
        end else begin : g_ps
            localparam int PSW = $clog2(DIV);
            logic [PSW-1:0] r_ps;

            assign w_tick = i_en && (r_ps == PSW'(DIV - 1));

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst)
                    r_ps <= '0;
                else if (i_clr || i_load || w_tick)
                    r_ps <= '0;
                else if (i_en)
                    r_ps <= r_ps + 1'b1;
            end
        end
    endgenerate

    assign w_at_max  = (r_cnt == LP_MAX);
    assign w_at_zero = (r_cnt == '0);
    assign w_at_lim  = i_up ? w_at_max : w_at_zero;
    assign w_ld      = ({1'b0, i_ld_val} >= LP_MOD) ? LP_MAX : {1'b0, i_ld_val};

`ifdef CNT_SAT_EN
    assign w_up_nx = w_at_max  ? LP_MAX : r_cnt + 1'b1;
    assign w_dn_nx = w_at_zero ? '0     : r_cnt - 1'b1;
    // Level output while parked at the limit; not qualified by the prescaler.
    assign o_tc    = !i_rst && !i_clr && !i_load && w_at_lim;
`else
    assign w_up_nx = w_at_max  ? '0     : r_cnt + 1'b1;
    assign w_dn_nx = w_at_zero ? LP_MAX : r_cnt - 1'b1;
    assign o_tc    = !i_rst && !i_clr && !i_load && w_tick && w_at_lim;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= w_ld;
        else if (w_tick)
            r_cnt <= i_up ? w_up_nx : w_dn_nx;
    end

    assign o_out = r_cnt[W-1:0];

endmodule
